// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester unified-memory arbiter.
// Imported by the arbiter top and its round-robin selector.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_DM
    } owner_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick between fetch and data requests.
// On contention the requester that did not own the last access wins.
module rr_select_2
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_owner,
    output logic pick_if,
    output logic pick_dm
);

    logic last_if;

    assign last_if = (last_owner == logic'(OWNER_IF));
    assign pick_dm = dm_req && (!if_req || last_if);
    assign pick_if = if_req && (!dm_req || !last_if);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store paths,
// with fair alternation, registered done pulses and an ack timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_done,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [WORD_W-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_done,
    output logic [WORD_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state;
    owner_t        owner;
    owner_t        last_owner;
    logic [CW-1:0] cnt;
    logic          pick_if;
    logic          pick_dm;
    logic          idle;
    logic          expire;

    rr_select_2 u_sel (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .last_owner (last_owner),
        .pick_if    (pick_if),
        .pick_dm    (pick_dm)
    );

    assign idle   = (state == IDLE);
    assign if_gnt = reset && idle && pick_if;
    assign dm_gnt = reset && idle && pick_dm;
    assign mem_en = (state == ACCESS);

    // Expiry is judged on the last allowed cycle so ACCESS lasts exactly
    // TIMEOUT_CYCLES cycles; an ack in that same cycle still completes.
    assign expire = (TIMEOUT_CYCLES != 0) &&
                    (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWNER_IF;
            last_owner  <= OWNER_IF;
            cnt         <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            if_done     <= 1'b0;
            dm_done     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if_done     <= 1'b0;
            dm_done     <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_if || pick_dm) begin
                        state      <= ACCESS;
                        cnt        <= '0;
                        owner      <= pick_dm ? OWNER_DM : OWNER_IF;
                        last_owner <= pick_dm ? OWNER_DM : OWNER_IF;
                        mem_we     <= pick_dm && dm_we;
                        mem_addr   <= pick_dm ? dm_addr : if_addr;
                        mem_wdata  <= pick_dm ? dm_wdata : '0;
                    end
                end
                ACCESS: begin
                    if (mem_ack || expire) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        rdata       <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        if_done     <= (owner == OWNER_IF);
                        dm_done     <= (owner == OWNER_DM);
                        timeout_err <= !mem_ack;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transfers, contention,
// timeout, spurious ack and asynchronous reset during an access.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_done;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    mem_arbiter #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_done     (if_done),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_gnt      (dm_gnt),
        .dm_done     (dm_done),
        .rdata       (rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic        dm;
        logic [31:0] rdata;
        logic        terr;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] gq[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int gnt_cyc = 0;

    // Memory responder knobs
    bit resp_on = 0;
    bit ack_en = 1;
    bit force_ack = 0;
    int ack_delay = 0;
    int en_cnt = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resp_on) begin
            if (mem_en) begin
                mem_ack = (ack_en && en_cnt == ack_delay) || force_ack;
                en_cnt++;
            end else begin
                mem_ack = force_ack;
                en_cnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT grants or completes
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (if_done || dm_done || timeout_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_done",
                          {61'd0, if_done, dm_done, timeout_err}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", {if_done, dm_done, timeout_err},
                          {!e.dm, e.dm, e.terr});
                    check("done_rdata", rdata, e.rdata);
                    check("done_latency", cyc - gnt_cyc, e.lat);
                end
            end
            if (if_gnt || dm_gnt) begin
                if (gq.size() == 0)
                    check("unexpected_gnt", {62'd0, if_gnt, dm_gnt}, 64'd0);
                else
                    check("gnt_order", {if_gnt, dm_gnt}, gq.pop_front());
                gnt_cyc = cyc;
            end
        end
    end

    task automatic expect_done(bit dm, logic [31:0] rd, bit terr, int lat);
        exp_t e;
        e.dm = dm;
        e.rdata = rd;
        e.terr = terr;
        e.lat = lat;
        sb.push_back(e);
        gq.push_back(dm ? 2'b01 : 2'b10);
    endtask

    task automatic wait_gnt(string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = if_gnt || dm_gnt;
        end
        if (!seen) check(nm, 0, 1);
    endtask

    task automatic wait_drain(string nm);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        check(nm, sb.size(), 0);
    endtask

    initial begin
        int n;
        int gap;
        int ens;
        bit seen;
        reset = 0;
        if_req = 0;
        if_addr = 0;
        dm_req = 0;
        dm_we = 0;
        dm_addr = 0;
        dm_wdata = 0;
        mem_rdata = 0;
        mem_ack = 0;

        // Reset held with random inputs: every output must read 0
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            {if_req, dm_req, dm_we, mem_ack} = 4'($urandom);
            if_addr = $urandom;
            dm_addr = $urandom;
            dm_wdata = $urandom;
            mem_rdata = $urandom;
            @(negedge clk);
            check("reset_outs", 64'(|{if_gnt, if_done, dm_gnt, dm_done,
                  rdata, mem_en, mem_we, mem_addr, mem_wdata,
                  timeout_err}), 0);
        end
        @(posedge clk);
        #1;
        {if_req, dm_req, dm_we, mem_ack} = '0;
        mem_rdata = 0;
        reset = 1;
        resp_on = 1;
        repeat (3) @(negedge clk);
        check("idle_mem_en", mem_en, 0);

        // Fetch read, ack two cycles after mem_en
        ack_delay = 2;
        mem_rdata = 32'h0050_0093;
        expect_done(0, 32'h0050_0093, 0, 4);
        @(posedge clk);
        #1;
        if_req = 1;
        if_addr = 32'h10;
        wait_gnt("fetch_gnt");
        @(posedge clk);
        #1;
        if_req = 0;
        @(negedge clk);
        check("fetch_mem_en", mem_en, 1);
        check("fetch_addr", mem_addr, 32'h10);
        check("fetch_we", mem_we, 0);
        wait_drain("fetch_drain");

        // Data write with same-cycle ack; read data must stay 0
        ack_delay = 0;
        expect_done(1, 32'h0, 0, 2);
        @(posedge clk);
        #1;
        dm_req = 1;
        dm_we = 1;
        dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF;
        wait_gnt("write_gnt");
        @(posedge clk);
        #1;
        dm_req = 0;
        @(negedge clk);
        check("write_we", mem_we, 1);
        check("write_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("write_addr", mem_addr, 32'h100);
        wait_drain("write_drain");

        // Contention straight out of reset: dm, if, dm, if
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        dm_we = 0;
        dm_addr = 32'h200;
        if_addr = 32'h20;
        mem_rdata = 32'h1111_1111;
        for (int k = 0; k < 2; k++) begin
            expect_done(1, 32'h1111_1111, 0, 2);
            expect_done(0, 32'h1111_1111, 0, 2);
        end
        if_req = 1;
        dm_req = 1;
        n = 0;
        gap = 0;
        seen = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (if_gnt || dm_gnt) n++;
            if (mem_en) begin
                if (seen) check("mem_en_gap", 64'(gap <= 1), 1);
                seen = 1;
                gap = 0;
            end else begin
                gap++;
            end
        end
        check("contention_gnts", n, 4);
        @(posedge clk);
        #1;
        if_req = 0;
        dm_req = 0;
        wait_drain("contention_drain");

        // Timeout: no ack for a dm read
        ack_en = 0;
        mem_rdata = 32'hCAFE_0001;
        expect_done(1, 32'h0, 1, 17);
        @(posedge clk);
        #1;
        dm_req = 1;
        dm_addr = 32'h300;
        wait_gnt("timeout_gnt");
        @(posedge clk);
        #1;
        dm_req = 0;
        ens = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (mem_en) ens++;
        end
        check("timeout_en_cycles", ens, 16);
        check("timeout_drain", sb.size(), 0);

        // Spurious ack in IDLE must produce nothing
        @(posedge clk);
        #1;
        force_ack = 1;
        @(posedge clk);
        #1;
        force_ack = 0;
        repeat (3) @(negedge clk);
        check("spurious_idle", mem_en, 0);

        // Ack on the final allowed cycle beats the timeout
        ack_en = 1;
        ack_delay = 15;
        expect_done(1, 32'hCAFE_0001, 0, 17);
        @(posedge clk);
        #1;
        dm_req = 1;
        dm_addr = 32'h304;
        wait_gnt("late_ack_gnt");
        @(posedge clk);
        #1;
        dm_req = 0;
        wait_drain("late_ack_drain");

        // Reset in the middle of an access
        ack_en = 0;
        gq.push_back(2'b10);
        @(posedge clk);
        #1;
        if_req = 1;
        if_addr = 32'h40;
        wait_gnt("abort_gnt");
        @(posedge clk);
        #1;
        if_req = 0;
        repeat (3) @(negedge clk);
        check("abort_before", mem_en, 1);
        #2;
        reset = 0;
        #1;
        check("abort_async_en", mem_en, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        ack_en = 1;
        ack_delay = 1;
        mem_rdata = 32'h0000_0513;
        expect_done(0, 32'h0000_0513, 0, 3);
        if_req = 1;
        if_addr = 32'h44;
        wait_gnt("reissue_gnt");
        @(posedge clk);
        #1;
        if_req = 0;
        @(negedge clk);
        check("reissue_addr", mem_addr, 32'h44);
        wait_drain("reissue_drain");
        repeat (3) @(posedge clk);
        check("gnt_queue_empty", gq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
